lnn_symbol_packer: RTL

Downstream stage of the linear-prediction core. It takes the 4-bit prediction-error symbols the core emits, one per clock while valid, and packs two symbols per byte. It frames each 96-symbol block as header byte, 48 data bytes and an XOR checksum byte. The bytes are buffered in a byte FIFO and presented on a valid/ready byte stream for the serial/host link.

---
 rtl/lnn_symbol_packer.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lnn_symbol_packer.sv
// Purpose: packs 4-bit prediction-error symbols two per byte and frames each
//          block as header, data bytes and XOR checksum into a byte FIFO.
// Latency/backpressure: a pushed byte is on byte_out the cycle after its push
//          edge (FWFT). There is no upstream backpressure: a push into a full
//          FIFO with no pop is dropped and sets the sticky overflow flag.
//
// Ports:
//   sys_clk      clock, rising edge
//   sys_reset    asynchronous, active-low reset
//   sym_in       4-bit error symbol, qualified by sym_valid
//   byte_ready   consumer accepts byte_out this cycle
//   byte_out     FIFO head byte (0 while empty)
//   byte_valid   FIFO not empty
//   frame_count  frames closed since reset, wraps at 256
//   overflow     sticky: a byte was dropped on a full FIFO
//   protocol_err sticky: a symbol arrived during the trailer cycle
//   busy         framer is inside a frame (not idle)

// Generic byte FIFO.
// Latency: one cycle push-to-head, head read combinationally (first-word fall-through).
// Backpressure: a push on a full FIFO is accepted only if a pop happens the same cycle; otherwise push_drop.
module lnn_byte_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] head_dat,
   output logic             head_vld,
   output logic             push_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   // Pointers carry one extra MSB so that equal low bits with a differing
   // MSB means full, and fully equal pointers means empty.
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   logic empty;
   logic full;
   logic pop;
   logic push_ok;

   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop       = !empty && pop_rdy;
      // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
      push_ok   = push_vld && (!full || pop);
      push_drop = push_vld && full && !pop;

      wr_ptr_d  = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d  = pop     ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

      mem_d = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      end

      head_vld = !empty;
      head_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// Symbol packer / framer.
// Latency: header and data bytes reach byte_out one cycle after the sampling edge; checksum one edge after the last symbol.
// Backpressure: none toward the core; a full FIFO drops bytes (overflow) while framing and checksum carry on.
module lnn_symbol_packer #(
   parameter int          SYMS_PER_FRAME = 96,
   parameter int          FIFO_DEPTH     = 16,
   parameter logic [7:0]  HEADER_BYTE    = 8'hA5
) (
   input  logic       sys_clk,
   input  logic       sys_reset,
   input  logic [3:0] sym_in,
   input  logic       sym_valid,
   input  logic       byte_ready,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic [7:0] frame_count,
   output logic       overflow,
   output logic       protocol_err,
   output logic       busy
);

   localparam int CW = $clog2(SYMS_PER_FRAME + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] LAST_IDX = CW'(SYMS_PER_FRAME - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PACK    = 2'd1,
      ST_TRAILER = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] sym_cnt_q, sym_cnt_d;       // index of the next symbol in the frame
   logic [3:0]    nib_q, nib_d;               // earlier symbol of the current pair
   logic [7:0]    csum_q, csum_d;             // XOR of the frame's data bytes
   logic [7:0]    frame_count_q, frame_count_d;
   logic          overflow_q, overflow_d;
   logic          protocol_err_q, protocol_err_d;

   logic          push_vld;
   logic [7:0]    push_dat;
   logic          push_drop;
   logic          busy_dat;

   // State register and datapath flops.
   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         state_q        <= ST_IDLE;
         sym_cnt_q      <= '0;
         nib_q          <= '0;
         csum_q         <= '0;
         frame_count_q  <= '0;
         overflow_q     <= 1'b0;
         protocol_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         sym_cnt_q      <= sym_cnt_d;
         nib_q          <= nib_d;
         csum_q         <= csum_d;
         frame_count_q  <= frame_count_d;
         overflow_q     <= overflow_d;
         protocol_err_q <= protocol_err_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (sym_valid) begin
               state_d = ST_PACK;
            end
         end
         ST_PACK: begin
            if (sym_valid && (sym_cnt_q == LAST_IDX)) begin
               state_d = ST_TRAILER;
            end
         end
         ST_TRAILER: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output / datapath logic. At most one byte is pushed per cycle:
   // header in IDLE, data on odd symbol indices in PACK, checksum in TRAILER.
   always_comb begin
      push_vld       = 1'b0;
      push_dat       = 8'h00;
      sym_cnt_d      = sym_cnt_q;
      nib_d          = nib_q;
      csum_d         = csum_q;
      frame_count_d  = frame_count_q;
      protocol_err_d = protocol_err_q;
      busy_dat       = (state_q != ST_IDLE);

      unique case (state_q)
         ST_IDLE: begin
            if (sym_valid) begin
               push_vld  = 1'b1;
               push_dat  = HEADER_BYTE;
               nib_d     = sym_in;
               sym_cnt_d = CNT_ONE;
            end
         end
         ST_PACK: begin
            if (sym_valid) begin
               sym_cnt_d = sym_cnt_q + CNT_ONE;
               if (sym_cnt_q[0]) begin
                  // Second symbol of a pair: earlier symbol is the high nibble.
                  // The checksum includes the byte even if the FIFO drops it.
                  push_vld = 1'b1;
                  push_dat = {nib_q, sym_in};
                  csum_d   = csum_q ^ {nib_q, sym_in};
               end else begin
                  nib_d = sym_in;
               end
            end
         end
         ST_TRAILER: begin
            push_vld      = 1'b1;
            push_dat      = csum_q;
            csum_d        = 8'h00;
            sym_cnt_d     = '0;
            frame_count_d = frame_count_q + 8'd1;
            // A symbol here is a framing violation; it is dropped, not carried into the next frame.
            if (sym_valid) begin
               protocol_err_d = 1'b1;
            end
         end
         default: begin
            busy_dat = 1'b0;
         end
      endcase
   end

   // Kept apart from the block above because push_drop depends on push_vld through the FIFO.
   always_comb begin
      overflow_d = overflow_q | push_drop;
   end

   lnn_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (sys_clk),
      .rst_n     (sys_reset),
      .push_vld  (push_vld),
      .push_dat  (push_dat),
      .pop_rdy   (byte_ready),
      .head_dat  (byte_out),
      .head_vld  (byte_valid),
      .push_drop (push_drop)
   );

   assign frame_count  = frame_count_q;
   assign overflow     = overflow_q;
   assign protocol_err = protocol_err_q;
   assign busy         = busy_dat;

endmodule
